mips_top: RTL and testbench

Bit-serial two's-complement adder used as the arithmetic datapath stub of the `mips` block. Two operand bit streams `a` and `b` arrive LSB-first, one bit per clock, framed into words of `WIDTH` bits by an internal bit counter. The block emits the registered sum bit `c` each cycle, plus word-boundary and signed-overflow strobes. It sits between the operand shift logic and the result write-back path.

---
 rtl/mips_top.sv | 97 +++++++++
 tb/tb_mips_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mips_top.sv
// mips_top: bit-serial two's-complement adder, LSB-first words of WIDTH bits.
// Ports: clk, rst_n (async active-low), a/b operand bits in; c registered sum bit,
//        word_done/ovf one-cycle MSB strobes; sum_word (MIPS_SUM_CAPTURE_EN only).
// Latency 1 cycle; no backpressure, the bit counter advances every cycle after reset.
// Optional feature macro: MIPS_SUM_CAPTURE_EN adds the sum shift register and sum_word.
module mips_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic             word_done,
  output logic             ovf
`ifdef MIPS_SUM_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] sum_word
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          cy_q, cy_d;
  logic          c_q, c_d;
  logic          wd_q, wd_d;
  logic          ovf_q, ovf_d;
  logic          s, co, is_msb;

  always_comb begin
    s      = a ^ b ^ cy_q;
    co     = (a & b) | (cy_q & (a ^ b));
    is_msb = (bcnt_q == LAST);
    c_d    = s;
    cy_d   = co;
    bcnt_d = bcnt_q + CW'(1);
    wd_d   = 1'b0;
    ovf_d  = 1'b0;
    if (is_msb) begin
      // Carry is cleared so words never chain; the unsigned carry-out is dropped.
      cy_d   = 1'b0;
      bcnt_d = '0;
      wd_d   = 1'b1;
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf_d  = cy_q ^ co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      cy_q   <= 1'b0;
      c_q    <= 1'b0;
      wd_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      cy_q   <= cy_d;
      c_q    <= c_d;
      wd_q   <= wd_d;
      ovf_q  <= ovf_d;
    end
  end

  assign c         = c_q;
  assign word_done = wd_q;
  assign ovf       = ovf_q;

`ifdef MIPS_SUM_CAPTURE_EN
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sw_q, sw_d;

  // Sum bits enter at the top so after WIDTH shifts the word sits LSB-aligned.
  always_comb begin
    sr_d = {s, sr_q[WIDTH-1:1]};
    sw_d = sw_q;
    if (is_msb) begin
      sw_d = sr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      sw_q <= '0;
    end else begin
      sr_q <= sr_d;
      sw_q <= sw_d;
    end
  end

  assign sum_word = sw_q;
`endif

endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: scoreboard bench for mips_top (WIDTH=8).
// Stimulus pushes expected per-bit results computed from whole-word arithmetic;
// a negedge monitor pops and compares against the registered outputs.
module tb_mips_top;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c, wd, ovf;
`ifdef MIPS_SUM_CAPTURE_EN
  logic [W-1:0] sum_word;
`endif

  mips_top #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .word_done (wd),
    .ovf       (ovf)
`ifdef MIPS_SUM_CAPTURE_EN
    ,
    .sum_word  (sum_word)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         c;
    logic         wd;
    logic         ov;
    logic [W-1:0] sw;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] last_sw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each entry corresponds to one bit sampled on the preceding rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("c", {31'd0, c}, {31'd0, mon_e.c});
      chk("word_done", {31'd0, wd}, {31'd0, mon_e.wd});
      chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ov});
`ifdef MIPS_SUM_CAPTURE_EN
      chk("sum_word", {24'd0, sum_word}, {24'd0, mon_e.sw});
`endif
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_c"}, {31'd0, c}, 32'd0);
    chk({tag, "_wd"}, {31'd0, wd}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`ifdef MIPS_SUM_CAPTURE_EN
    chk({tag, "_sw"}, {24'd0, sum_word}, 32'd0);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the bit is sampled.
  task automatic send_bit(input logic ai, input logic bi, input logic ce,
                          input logic wde, input logic ove, input logic [W-1:0] swe);
    exp_t e;
    a = ai;
    b = bi;
    @(posedge clk);
    e.c  = ce;
    e.wd = wde;
    e.ov = ove;
    e.sw = swe;
    q.push_back(e);
    #1;
  endtask

  // Whole-word reference: W-bit modular sum, signed overflow from operand/result signs.
  task automatic send_word(input logic [W-1:0] wa, input logic [W-1:0] wb);
    logic [W-1:0] sum;
    logic         ov;
    sum = wa + wb;
    ov  = (wa[W-1] == wb[W-1]) && (sum[W-1] != wa[W-1]);
    for (int i = 0; i < W; i++) begin
      send_bit(wa[i], wb[i], sum[i], i == W-1, (i == W-1) ? ov : 1'b0,
               (i == W-1) ? sum : last_sw);
    end
    last_sw = sum;
  endtask

  // Asserts reset between edges, checks immediate clear, releases after one edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    last_sw = '0;
    a = 1'($urandom);
    b = 1'($urandom);
    @(posedge clk);
    #1;
    check_outputs_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  logic [W-1:0] pa, pb, psum;

  initial begin
    // Reset held from time zero with random operands.
    #2;
    check_outputs_zero("rst_init");
    for (int i = 0; i < 3; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs_zero("rst_hold_rand");
    end
    rst_n = 1'b1;

    // a=0, b=1 continuously: all-ones sum, word_done every W cycles.
    for (int i = 0; i < 3; i++) send_word(8'h00, 8'hFF);
    send_word(8'h05, 8'h03);
    send_word(8'h7F, 8'h01);
    send_word(8'hFF, 8'h01);
    send_word(8'h00, 8'h00);
    send_word(8'h80, 8'h80);

    // Partial word of 3 bits, then reset mid-word.
    pa = 8'($urandom);
    pb = 8'($urandom);
    psum = pa + pb;
    for (int i = 0; i < 3; i++) send_bit(pa[i], pb[i], psum[i], 1'b0, 1'b0, last_sw);
    do_reset();
    send_word(8'h12, 8'h34);

    for (int i = 0; i < 40; i++) send_word(8'($urandom), 8'($urandom));
    do_reset();
    for (int i = 0; i < 10; i++) send_word(8'($urandom), 8'($urandom));

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
